instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 155 +++++++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with one-entry skid buffer and redirect
// Optional macro IF_PERF_CNT_EN adds FETCH_CNT / REDIRECT_CNT performance counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_n,
    output logic [31:0] INS_ADDRESS,
    input  logic [31:0] INSTRUCTION,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic        IF_VALID,
    input  logic        IF_READY,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] FETCH_CNT,
    output logic [31:0] REDIRECT_CNT
`endif
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc_f;
    logic [31:0] r_pc_d;
    logic        r_inflight;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        w_xfer;
    logic        w_issue;
    logic [1:0]  w_occupancy;

    assign w_xfer      = r_if_valid & IF_READY;
    // Entries that will still be held after this edge; at most three, never negative.
    assign w_occupancy = {1'b0, r_if_valid} + {1'b0, r_skid_valid}
                       + {1'b0, r_inflight} - {1'b0, w_xfer};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_issue = (w_occupancy <= 2'd1) && !BR_TAKEN;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_pc_f       <= RESET_PC;
            r_pc_d       <= 32'h0000_0000;
            r_inflight   <= 1'b0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'h0000_0000;
            r_if_instr   <= NOP_INSTR;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0000_0000;
            r_skid_instr <= NOP_INSTR;
        end else if (BR_TAKEN) begin
            r_pc_f       <= BR_TARGET & 32'hFFFF_FFFC;
            r_inflight   <= 1'b0;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pc_f     <= r_pc_f + 32'd4;
                r_pc_d     <= r_pc_f;
                r_inflight <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end

            if (w_xfer || !r_if_valid) begin
                // Output slot frees up: the older skid entry goes first to keep program order.
                if (r_skid_valid) begin
                    r_if_valid   <= 1'b1;
                    r_if_pc      <= r_skid_pc;
                    r_if_instr   <= r_skid_instr;
                    r_skid_valid <= r_inflight;
                    if (r_inflight) begin
                        r_skid_pc    <= r_pc_d;
                        r_skid_instr <= INSTRUCTION;
                    end
                end else if (r_inflight) begin
                    r_if_valid <= 1'b1;
                    r_if_pc    <= r_pc_d;
                    r_if_instr <= INSTRUCTION;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end else if (r_inflight) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_pc_d;
                r_skid_instr <= INSTRUCTION;
            end
        end
    end

    assign INS_ADDRESS = r_pc_f;
    assign IF_VALID    = r_if_valid;
    assign IF_PC       = r_if_pc;
    assign IF_INSTR    = r_if_instr;
    assign IF_PC4      = r_if_pc + 32'd4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    // A transfer coinciding with a redirect was still delivered, so it is counted.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_fetch_cnt    <= 32'h0000_0000;
            r_redirect_cnt <= 32'h0000_0000;
        end else begin
            if (w_xfer) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (BR_TAKEN) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign FETCH_CNT    = r_fetch_cnt;
    assign REDIRECT_CNT = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        CLK;
    logic        RST_n;
    logic [31:0] INS_ADDRESS;
    logic [31:0] INSTRUCTION;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_PC;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] FETCH_CNT;
    logic [31:0] REDIRECT_CNT;
`endif

    int          checks;
    int          failures;
    logic [31:0] g_exp_pc;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .INS_ADDRESS (INS_ADDRESS),
        .INSTRUCTION (INSTRUCTION),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .IF_VALID    (IF_VALID),
        .IF_READY    (IF_READY),
        .IF_PC       (IF_PC),
        .IF_INSTR    (IF_INSTR),
        .IF_PC4      (IF_PC4)
`ifdef IF_PERF_CNT_EN
        ,
        .FETCH_CNT   (FETCH_CNT),
        .REDIRECT_CNT(REDIRECT_CNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ROM model: word at byte address A is A/4, presented the cycle after sampling.
    always @(posedge CLK) begin
        INSTRUCTION <= INS_ADDRESS >> 2;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_n = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 32'h0; IF_READY = 1'b1;
        tick(); tick();
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", IF_VALID); end
        checks++; if (IF_PC !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h exp 00000000", IF_PC); end
        checks++; if (IF_INSTR !== 32'h13) begin failures++; $display("FAIL rst_instr: got %h exp 00000013", IF_INSTR); end
        checks++; if (INS_ADDRESS !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h exp 00000000", INS_ADDRESS); end
        checks++; if (IF_PC4 !== 32'h4) begin failures++; $display("FAIL rst_pc4: got %h exp 00000004", IF_PC4); end
    endtask

    task automatic test_startup_stream();
        RST_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (IF_VALID !== (e == 3)) begin
                failures++; $display("FAIL start_valid_edge%0d: got %b exp %b", e, IF_VALID, (e == 3));
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (IF_VALID !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, IF_VALID); end
            checks++; if (IF_PC !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, IF_PC, 32'(4 * i)); end
            checks++; if (IF_INSTR !== 32'(i)) begin failures++; $display("FAIL stream_instr[%0d]: got %h exp %h", i, IF_INSTR, 32'(i)); end
            tick();
        end
        g_exp_pc = 32'd32;
    endtask

    task automatic test_stall();
        logic [31:0] held_addr;
        held_addr = INS_ADDRESS;
        IF_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (IF_VALID !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b exp 1", k, IF_VALID); end
            checks++; if (IF_PC !== g_exp_pc) begin failures++; $display("FAIL stall_pc[%0d]: got %h exp %h", k, IF_PC, g_exp_pc); end
            checks++; if (IF_INSTR !== (g_exp_pc >> 2)) begin failures++; $display("FAIL stall_instr[%0d]: got %h exp %h", k, IF_INSTR, g_exp_pc >> 2); end
            checks++; if (INS_ADDRESS !== held_addr) begin failures++; $display("FAIL stall_addr[%0d]: got %h exp %h", k, INS_ADDRESS, held_addr); end
        end
        IF_READY = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            g_exp_pc = g_exp_pc + 32'd4;
            checks++; if (IF_VALID !== 1'b1) begin failures++; $display("FAIL resume_valid[%0d]: got %b exp 1", j, IF_VALID); end
            checks++; if (IF_PC !== g_exp_pc) begin failures++; $display("FAIL resume_pc[%0d]: got %h exp %h", j, IF_PC, g_exp_pc); end
            checks++; if (IF_INSTR !== (g_exp_pc >> 2)) begin failures++; $display("FAIL resume_instr[%0d]: got %h exp %h", j, IF_INSTR, g_exp_pc >> 2); end
        end
    endtask

    task automatic test_redirect();
        IF_READY = 1'b0;
        tick(); tick();
        BR_TAKEN = 1'b1; BR_TARGET = 32'h0000_0103;
        tick();
        BR_TAKEN = 1'b0; IF_READY = 1'b1;
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL redir_valid_t1: got %b exp 0", IF_VALID); end
        checks++; if (INS_ADDRESS !== 32'h100) begin failures++; $display("FAIL redir_addr_t1: got %h exp 00000100", INS_ADDRESS); end
        tick();
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL redir_valid_t2: got %b exp 0", IF_VALID); end
        tick();
        checks++; if (IF_VALID !== 1'b1) begin failures++; $display("FAIL redir_valid_t3: got %b exp 1", IF_VALID); end
        checks++; if (IF_PC !== 32'h100) begin failures++; $display("FAIL redir_pc_t3: got %h exp 00000100", IF_PC); end
        checks++; if (IF_INSTR !== 32'd64) begin failures++; $display("FAIL redir_instr_t3: got %h exp 00000040", IF_INSTR); end
        tick();
        checks++; if (IF_PC !== 32'h104) begin failures++; $display("FAIL redir_pc_t4: got %h exp 00000104", IF_PC); end
        checks++; if (IF_INSTR !== 32'd65) begin failures++; $display("FAIL redir_instr_t4: got %h exp 00000041", IF_INSTR); end
    endtask

    task automatic test_wrap();
        IF_READY = 1'b1;
        BR_TAKEN = 1'b1; BR_TARGET = 32'hFFFF_FFFC;
        tick();
        BR_TAKEN = 1'b0;
        checks++; if (INS_ADDRESS !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0: got %h exp fffffffc", INS_ADDRESS); end
        tick();
        checks++; if (INS_ADDRESS !== 32'h0) begin failures++; $display("FAIL wrap_addr1: got %h exp 00000000", INS_ADDRESS); end
        tick();
        checks++; if (IF_PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc: got %h exp fffffffc", IF_PC); end
        checks++; if (IF_PC4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4: got %h exp 00000000", IF_PC4); end
        checks++; if (IF_INSTR !== 32'h3FFF_FFFF) begin failures++; $display("FAIL wrap_instr: got %h exp 3fffffff", IF_INSTR); end
        tick();
        checks++; if (IF_PC !== 32'h0) begin failures++; $display("FAIL wrap_next_pc: got %h exp 00000000", IF_PC); end
        checks++; if (IF_INSTR !== 32'h0) begin failures++; $display("FAIL wrap_next_instr: got %h exp 00000000", IF_INSTR); end
    endtask

    task automatic test_back_to_back();
        BR_TAKEN = 1'b1; BR_TARGET = 32'h0000_0200;
        tick();
        BR_TARGET = 32'h0000_0302;
        tick();
        BR_TAKEN = 1'b0;
        checks++; if (INS_ADDRESS !== 32'h300) begin failures++; $display("FAIL b2b_addr: got %h exp 00000300", INS_ADDRESS); end
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL b2b_valid_t1: got %b exp 0", IF_VALID); end
        tick();
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL b2b_valid_t2: got %b exp 0", IF_VALID); end
        tick();
        checks++; if (IF_PC !== 32'h300) begin failures++; $display("FAIL b2b_pc: got %h exp 00000300", IF_PC); end
        checks++; if (IF_INSTR !== 32'hC0) begin failures++; $display("FAIL b2b_instr: got %h exp 000000c0", IF_INSTR); end
    endtask

    task automatic test_reset_mid();
        IF_READY = 1'b1;
        tick(); tick();
        IF_READY = 1'b0;
        tick(); tick();
        RST_n = 1'b0;
        #1;
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b exp 0", IF_VALID); end
        checks++; if (IF_PC !== 32'h0) begin failures++; $display("FAIL mid_rst_pc: got %h exp 00000000", IF_PC); end
        checks++; if (IF_INSTR !== 32'h13) begin failures++; $display("FAIL mid_rst_instr: got %h exp 00000013", IF_INSTR); end
        checks++; if (INS_ADDRESS !== 32'h0) begin failures++; $display("FAIL mid_rst_addr: got %h exp 00000000", INS_ADDRESS); end
        IF_READY = 1'b1;
        tick();
        RST_n = 1'b1;
        tick(); tick();
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL mid_restart_valid_e2: got %b exp 0", IF_VALID); end
        tick();
        checks++; if (IF_VALID !== 1'b1) begin failures++; $display("FAIL mid_restart_valid_e3: got %b exp 1", IF_VALID); end
        checks++; if (IF_PC !== 32'h0) begin failures++; $display("FAIL mid_restart_pc0: got %h exp 00000000", IF_PC); end
        tick();
        checks++; if (IF_PC !== 32'h4) begin failures++; $display("FAIL mid_restart_pc1: got %h exp 00000004", IF_PC); end
        checks++; if (IF_INSTR !== 32'h1) begin failures++; $display("FAIL mid_restart_instr1: got %h exp 00000001", IF_INSTR); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        RST_n = 1'b0; IF_READY = 1'b0; BR_TAKEN = 1'b0;
        tick();
        checks++; if (FETCH_CNT !== 32'd0) begin failures++; $display("FAIL perf_rst_fetch: got %0d exp 0", FETCH_CNT); end
        checks++; if (REDIRECT_CNT !== 32'd0) begin failures++; $display("FAIL perf_rst_redir: got %0d exp 0", REDIRECT_CNT); end
        RST_n = 1'b1; IF_READY = 1'b1;
        tick(); tick(); tick();
        repeat (10) tick();
        IF_READY = 1'b0;
        BR_TAKEN = 1'b1; BR_TARGET = 32'h40;
        tick(); tick();
        BR_TAKEN = 1'b0;
        tick();
        checks++; if (FETCH_CNT !== 32'd10) begin failures++; $display("FAIL perf_fetch: got %0d exp 10", FETCH_CNT); end
        checks++; if (REDIRECT_CNT !== 32'd2) begin failures++; $display("FAIL perf_redir: got %0d exp 2", REDIRECT_CNT); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        g_exp_pc = 32'h0;
        RST_n    = 1'b0;
        BR_TAKEN = 1'b0;
        BR_TARGET = 32'h0;
        IF_READY = 1'b1;
        test_reset();
        test_startup_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
